// File: rtl/uart_pkg.sv
// Shared rate codes, autobaud threshold helpers and state encodings for the
// UART baud-rate configuration controller.
package uart_pkg;

  localparam logic [1:0] BAUD_2400  = 2'b00;
  localparam logic [1:0] BAUD_4800  = 2'b01;
  localparam logic [1:0] BAUD_9600  = 2'b10;
  localparam logic [1:0] BAUD_19200 = 2'b11;

  localparam int unsigned CLK_FREQ_DEF = 100_000_000;

  typedef logic [16:0] cnt_t;

  // Midpoint between the bit time at baud and at 2*baud, i.e. 3/4 of bit(baud).
  function automatic cnt_t thr_mid(input longint unsigned clk_freq,
                                   input longint unsigned baud);
    return cnt_t'((clk_freq * 64'd3) / (baud * 64'd4));
  endfunction

  function automatic cnt_t thr_max(input longint unsigned clk_freq);
    return cnt_t'((clk_freq * 64'd5) / (64'd2400 * 64'd4));
  endfunction

  localparam cnt_t T_2400  = thr_mid(CLK_FREQ_DEF, 2400);
  localparam cnt_t T_4800  = thr_mid(CLK_FREQ_DEF, 4800);
  localparam cnt_t T_9600  = thr_mid(CLK_FREQ_DEF, 9600);
  localparam cnt_t T_19200 = thr_mid(CLK_FREQ_DEF, 19200);
  localparam cnt_t T_MAX   = thr_max(CLK_FREQ_DEF);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_IDLE,
    ST_APPLY,
    ST_SETTLE,
    ST_DONE,
    ST_AUTO,
    ST_FAIL
  } ctrl_st_e;

  typedef enum logic [1:0] {
    AB_IDLE,
    AB_ARM,
    AB_FALL,
    AB_MEAS
  } ab_st_e;

endpackage

// File: rtl/uart_autobaud_meas.sv
// Autobaud: arm on idle line, time the start bit of a 0x55 frame, classify it.
// done/fail are combinational single-cycle pulses; i_start is ignored unless idle.
module uart_autobaud_meas
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_DEF,
  parameter int unsigned AUTO_TIMEOUT = 100_000_000
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_rx,
  output logic       o_done,
  output logic       o_fail,
  output logic [1:0] o_rate
);

  localparam cnt_t LP_T24       = thr_mid(CLK_FREQ, 2400);
  localparam cnt_t LP_T48       = thr_mid(CLK_FREQ, 4800);
  localparam cnt_t LP_T96       = thr_mid(CLK_FREQ, 9600);
  localparam cnt_t LP_T192      = thr_mid(CLK_FREQ, 19200);
  localparam cnt_t LP_TMAX_LAST = thr_max(CLK_FREQ) - cnt_t'(1);

  localparam int TO_W = $clog2(AUTO_TIMEOUT + 1);
  typedef logic [TO_W-1:0] to_t;
  localparam to_t LP_TO_LAST = to_t'(AUTO_TIMEOUT - 1);

  ab_st_e     r_state;
  ab_st_e     w_next;
  to_t        r_to_cnt;
  cnt_t       r_meas_cnt;
  logic       w_to_hit;
  logic       w_meas_full;
  logic       w_cls_ok;
  logic [1:0] w_cls;

  assign w_to_hit    = (r_to_cnt == LP_TO_LAST);
  assign w_meas_full = (r_meas_cnt == LP_TMAX_LAST);
  assign o_rate      = w_cls;

  always_comb begin
    w_cls    = BAUD_19200;
    w_cls_ok = 1'b1;
    if (r_meas_cnt >= LP_T24)       w_cls = BAUD_2400;
    else if (r_meas_cnt >= LP_T48)  w_cls = BAUD_4800;
    else if (r_meas_cnt >= LP_T96)  w_cls = BAUD_9600;
    else if (r_meas_cnt >= LP_T192) w_cls = BAUD_19200;
    else                            w_cls_ok = 1'b0;
  end

  always_comb begin
    w_next = r_state;
    o_done = 1'b0;
    o_fail = 1'b0;
    case (r_state)
      AB_IDLE: if (i_start) w_next = AB_ARM;
      AB_ARM: begin
        if (i_rx) w_next = AB_FALL;
        else if (w_to_hit) begin
          w_next = AB_IDLE;
          o_fail = 1'b1;
        end
      end
      AB_FALL: begin
        if (!i_rx) w_next = AB_MEAS;
        else if (w_to_hit) begin
          w_next = AB_IDLE;
          o_fail = 1'b1;
        end
      end
      AB_MEAS: begin
        if (i_rx) begin
          w_next = AB_IDLE;
          o_done = w_cls_ok;
          o_fail = !w_cls_ok;
        end else if (w_meas_full) begin
          w_next = AB_IDLE;
          o_fail = 1'b1;
        end
      end
      default: w_next = AB_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state    <= AB_IDLE;
      r_to_cnt   <= '0;
      r_meas_cnt <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        AB_IDLE: if (i_start) r_to_cnt <= '0;
        AB_ARM:  r_to_cnt <= r_to_cnt + to_t'(1);
        AB_FALL: begin
          r_to_cnt <= r_to_cnt + to_t'(1);
          // The cycle that sees the falling edge is the first low cycle.
          if (!i_rx) r_meas_cnt <= cnt_t'(1);
        end
        AB_MEAS: if (!i_rx && r_meas_cnt != '1) r_meas_cnt <= r_meas_cnt + cnt_t'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/uart_baud_ctrl.sv
// Baud-rate config controller: manual or autobaud request, apply when TX/RX idle, settle.
// req_ready only in IDLE; requests and auto_req pulses while busy are dropped.
module uart_baud_ctrl
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = CLK_FREQ_DEF,
  parameter logic [1:0]  DEFAULT_RATE = BAUD_9600,
  parameter int unsigned SETTLE_TICKS = 4,
  parameter int unsigned AUTO_TIMEOUT = 100_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       req_valid,
  input  logic [1:0] req_rate,
  output logic       req_ready,
  input  logic       auto_req,
  input  logic       rx_in,
  input  logic       tx_busy,
  input  logic       rx_busy,
  input  logic       baud_clk_in,
  output logic [1:0] baud_rate,
  output logic       busy,
  output logic       cfg_done,
  output logic       auto_fail
);

  localparam int ST_W = $clog2(SETTLE_TICKS + 1);
  typedef logic [ST_W-1:0] settle_t;
  localparam settle_t LP_SETTLE_LAST = settle_t'(SETTLE_TICKS - 1);

  ctrl_st_e   r_state;
  ctrl_st_e   w_next;
  logic [1:0] r_pend_rate;
  logic [1:0] r_baud_rate;
  settle_t    r_settle_cnt;
  logic       r_baud_clk_q;
  logic       w_rise;
  logic       w_meas_start;
  logic       w_meas_done;
  logic       w_meas_fail;
  logic [1:0] w_meas_rate;

  uart_autobaud_meas #(
    .CLK_FREQ    (CLK_FREQ),
    .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) u_meas (
    .i_clk  (clk),
    .i_rst  (rst),
    .i_start(w_meas_start),
    .i_rx   (rx_in),
    .o_done (w_meas_done),
    .o_fail (w_meas_fail),
    .o_rate (w_meas_rate)
  );

  assign w_rise    = baud_clk_in && !r_baud_clk_q;
  assign req_ready = (r_state == ST_IDLE);
  assign busy      = !req_ready;
  assign cfg_done  = (r_state == ST_DONE);
  assign auto_fail = (r_state == ST_FAIL);
  assign baud_rate = r_baud_rate;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next       = r_state;
    w_meas_start = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Manual request has priority over a coincident autobaud pulse.
        if (req_valid) w_next = ST_WAIT_IDLE;
        else if (auto_req) begin
          w_next       = ST_AUTO;
          w_meas_start = 1'b1;
        end
      end
      ST_WAIT_IDLE: if (!tx_busy && !rx_busy) w_next = ST_APPLY;
      ST_APPLY:     w_next = ST_SETTLE;
      ST_SETTLE:    if (w_rise && r_settle_cnt == LP_SETTLE_LAST) w_next = ST_DONE;
      ST_DONE:      w_next = ST_IDLE;
      ST_AUTO: begin
        if (w_meas_done)      w_next = ST_WAIT_IDLE;
        else if (w_meas_fail) w_next = ST_FAIL;
      end
      ST_FAIL:      w_next = ST_IDLE;
      default:      w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_pend_rate  <= DEFAULT_RATE;
      r_baud_rate  <= DEFAULT_RATE;
      r_settle_cnt <= '0;
      r_baud_clk_q <= 1'b0;
    end else begin
      r_baud_clk_q <= baud_clk_in;
      case (r_state)
        ST_IDLE:   if (req_valid) r_pend_rate <= req_rate;
        ST_AUTO:   if (w_meas_done) r_pend_rate <= w_meas_rate;
        ST_APPLY: begin
          r_baud_rate  <= r_pend_rate;
          r_settle_cnt <= '0;
        end
        ST_SETTLE: if (w_rise) r_settle_cnt <= r_settle_cnt + settle_t'(1);
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_baud_ctrl.sv
// Scoreboard bench for uart_baud_ctrl, run at a 10 MHz CLK_FREQ to keep autobaud short.
// At 10 MHz: thresholds 3125/1562/781/390, T_MAX 5208, bit times 4167/2083/1042/521.
module tb_uart_baud_ctrl;

  localparam int unsigned CLK_FREQ     = 10_000_000;
  localparam int unsigned AUTO_TIMEOUT = 2000;
  localparam int          SETTLE_TICKS = 4;
  localparam int          T_MAX        = 5208;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       req_valid = 1'b0;
  logic [1:0] req_rate = 2'b00;
  logic       req_ready;
  logic       auto_req = 1'b0;
  logic       rx_in = 1'b1;
  logic       tx_busy = 1'b0;
  logic       rx_busy = 1'b0;
  logic       baud_clk_in = 1'b0;
  logic [1:0] baud_rate;
  logic       busy;
  logic       cfg_done;
  logic       auto_fail;

  uart_baud_ctrl #(
    .CLK_FREQ    (CLK_FREQ),
    .DEFAULT_RATE(2'b10),
    .SETTLE_TICKS(SETTLE_TICKS),
    .AUTO_TIMEOUT(AUTO_TIMEOUT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_rate   (req_rate),
    .req_ready  (req_ready),
    .auto_req   (auto_req),
    .rx_in      (rx_in),
    .tx_busy    (tx_busy),
    .rx_busy    (rx_busy),
    .baud_clk_in(baud_clk_in),
    .baud_rate  (baud_rate),
    .busy       (busy),
    .cfg_done   (cfg_done),
    .auto_fail  (auto_fail)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit         is_fail;
    logic [1:0] rate;
    int         at_cyc;
    bit         chk_rises;
  } ev_t;

  ev_t        sb[$];
  int         rd_idx = 0;
  int         n_tests = 0;
  int         n_fail = 0;
  int         cyc = 0;
  int         rises = 0;
  int         rise_base = 0;
  logic       bprev = 1'b0;
  logic [1:0] last_rate = 2'b10;
  logic [1:0] cur_rate = 2'b10;
  int         bdiv = 0;

  // Autobaud vectors: low-pulse length and expected code (-1 = auto_fail).
  int ab_len[7]  = '{521, 4167, 1042, 2083, 389, 390, 5207};
  int ab_code[7] = '{3,   0,    2,    1,    -1,  3,   0};

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic push(input bit is_fail, input logic [1:0] rate, input int at_cyc,
                      input bit chk);
    ev_t e;
    e.is_fail   = is_fail;
    e.rate      = rate;
    e.at_cyc    = at_cyc;
    e.chk_rises = chk;
    sb.push_back(e);
  endtask

  task automatic drain(input int budget);
    int k = 0;
    while (rd_idx < sb.size() && k < budget) begin
      tick();
      k++;
    end
    check("event drain pending", sb.size() - rd_idx, 0);
    tick();
    check("idle after event", int'(busy), 0);
  endtask

  task automatic auto_run(input int n_low, input int code);
    logic [1:0] exp_rate;
    exp_rate = (code < 0) ? cur_rate : code[1:0];
    push(code < 0, exp_rate, -1, (code >= 0) && (exp_rate != cur_rate));
    auto_req = 1'b1;
    tick();
    auto_req = 1'b0;
    tick();
    tick();
    rx_in = 1'b0;
    repeat (n_low) tick();
    rx_in = 1'b1;
    drain(400);
    cur_rate = exp_rate;
  endtask

  // Free-running baud generator toggle, period 16 clk cycles.
  always @(negedge clk) begin
    bdiv++;
    if (bdiv == 8) begin
      bdiv = 0;
      baud_clk_in = ~baud_clk_in;
    end
  end

  always @(posedge clk) begin
    cyc++;
    if (baud_clk_in && !bprev) rises++;
    bprev = baud_clk_in;
  end

  // Monitor: pops one expected event per cfg_done/auto_fail pulse.
  always @(negedge clk) begin
    ev_t e;
    if (baud_rate !== last_rate) begin
      rise_base = rises;
      last_rate = baud_rate;
    end
    if (!rst && (cfg_done || auto_fail)) begin
      if (rd_idx >= sb.size()) begin
        check("unexpected pulse", int'({cfg_done, auto_fail}), 0);
      end else begin
        e = sb[rd_idx];
        rd_idx++;
        check("event is auto_fail", int'(auto_fail), int'(e.is_fail));
        check("event is cfg_done", int'(cfg_done), int'(!e.is_fail));
        check("baud_rate at event", int'(baud_rate), int'(e.rate));
        if (e.at_cyc >= 0) check("event cycle", cyc, e.at_cyc);
        if (e.chk_rises) check("settle rising edges", rises - rise_base, SETTLE_TICKS);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time %0t reached limit 2000000", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int bad;
    int k;
    // 1: reset state, then reset in the middle of SETTLE
    repeat (3) tick();
    check("reset baud_rate", int'(baud_rate), 2);
    check("reset req_ready", int'(req_ready), 1);
    check("reset busy", int'(busy), 0);
    check("reset cfg_done", int'(cfg_done), 0);
    check("reset auto_fail", int'(auto_fail), 0);
    rst = 1'b0;
    tick();
    req_valid = 1'b1;
    req_rate  = 2'b11;
    tick();
    req_valid = 1'b0;
    tick();
    tick();
    check("applied before reset", int'(baud_rate), 3);
    repeat (5) tick();
    check("busy in settle", int'(busy), 1);
    rst = 1'b1;
    tick();
    check("rate after mid-settle reset", int'(baud_rate), 2);
    check("ready after mid-settle reset", int'(req_ready), 1);
    rst = 1'b0;
    tick();

    // 2: manual request held off by tx_busy
    tx_busy   = 1'b1;
    req_valid = 1'b1;
    req_rate  = 2'b00;
    check("req_ready before accept", int'(req_ready), 1);
    push(1'b0, 2'b00, -1, 1'b1);
    tick();
    req_valid = 1'b0;
    bad = 0;
    for (int i = 0; i < 500; i++) begin
      tick();
      if (baud_rate != 2'b10 || req_ready != 1'b0) bad++;
    end
    check("hold while tx_busy", bad, 0);
    tx_busy = 1'b0;
    tick();
    check("rate before apply", int'(baud_rate), 2);
    tick();
    check("rate after apply", int'(baud_rate), 0);
    drain(400);
    cur_rate = 2'b00;

    // 3/4: autobaud classification and boundaries
    for (int i = 0; i < 7; i++) auto_run(ab_len[i], ab_code[i]);

    // 4: start bit held low past T_MAX
    auto_req = 1'b1;
    tick();
    auto_req = 1'b0;
    tick();
    tick();
    rx_in = 1'b0;
    push(1'b1, cur_rate, cyc + T_MAX, 1'b0);
    repeat (T_MAX + 20) tick();
    rx_in = 1'b1;
    drain(50);

    // 5: no falling edge within AUTO_TIMEOUT
    push(1'b1, cur_rate, cyc + 1 + AUTO_TIMEOUT, 1'b0);
    auto_req = 1'b1;
    tick();
    auto_req = 1'b0;
    k = 0;
    while (!auto_fail && k < AUTO_TIMEOUT + 50) begin
      tick();
      k++;
    end
    check("timeout auto_fail seen", int'(auto_fail), 1);
    tick();
    check("busy after timeout", int'(busy), 0);
    drain(10);

    // 6: manual beats coincident auto_req; requests while busy are dropped
    tx_busy   = 1'b1;
    req_valid = 1'b1;
    req_rate  = 2'b01;
    auto_req  = 1'b1;
    push(1'b0, 2'b01, -1, 1'b1);
    tick();
    req_valid = 1'b0;
    auto_req  = 1'b0;
    tick();
    req_valid = 1'b1;
    req_rate  = 2'b11;
    auto_req  = 1'b1;
    check("req_ready while busy", int'(req_ready), 0);
    tick();
    req_valid = 1'b0;
    auto_req  = 1'b0;
    repeat (20) tick();
    check("rate held in wait_idle", int'(baud_rate), 0);
    tx_busy = 1'b0;
    drain(400);
    check("rate after manual win", int'(baud_rate), 1);
    cur_rate = 2'b01;
    push(1'b0, 2'b01, -1, 1'b0);
    req_valid = 1'b1;
    req_rate  = 2'b01;
    tick();
    req_valid = 1'b0;
    drain(400);

    check("scoreboard leftover", sb.size() - rd_idx, 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_baud_ctrl.md
Name: uart_baud_ctrl

Overview:
Run-time configuration controller for the UART receive-side baud generator.
- Accepts manual baud-rate change requests through a valid/ready handshake.
- Alternatively auto-detects the rate from the start-bit width of a 0x55 ('U') frame on the RX line.
- Applies a new rate only when TX and RX are idle, then waits for the generator to settle before signalling completion.
- Sits between the host/config register block and the baud generator's 2-bit rate-select input.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- DEFAULT_RATE, 2'b10, rate code driven at reset (9600).
- SETTLE_TICKS, 4, number of baud_clk_in rising edges to wait after applying a rate.
- AUTO_TIMEOUT, 100_000_000, clk cycles allowed from auto start to the falling edge of rx_in.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- req_valid  in  1  manual rate-change request.
- req_rate  in  2  requested code: 00=2400, 01=4800, 10=9600, 11=19200.
- req_ready  out  1  controller can accept a manual request.
- auto_req  in  1  single-cycle pulse that starts autobaud.
- rx_in  in  1  RX line, already synchronised to clk.
- tx_busy  in  1  transmitter mid-frame.
- rx_busy  in  1  receiver mid-frame.
- baud_clk_in  in  1  toggle output of the baud generator.
- baud_rate  out  2  rate select driven to the baud generator.
- busy  out  1  controller not in IDLE.
- cfg_done  out  1  one-cycle pulse when the new rate has settled.
- auto_fail  out  1  one-cycle pulse when autobaud aborts.

Behaviour:
- One clock (clk). Reset rst is synchronous, active-high.
- Reset values: state=IDLE, baud_rate=DEFAULT_RATE, cfg_done=0, auto_fail=0, all counters 0.
- req_ready = (state==IDLE); busy = !req_ready. Both are combinational decodes of the state.
- A reset mid-operation aborts any sequence and restores DEFAULT_RATE on the next edge.
- States:
  - IDLE:
    - req_valid&&req_ready: latch req_rate into pend_rate, go to WAIT_IDLE.
    - else auto_req: go to AUTO_ARM and clear the timeout counter.
    - If both are asserted in the same cycle, manual wins and auto_req is dropped.
  - WAIT_IDLE: stay while tx_busy||rx_busy. When both are low, go to APPLY.
  - APPLY, one cycle: baud_rate<=pend_rate; clear the settle counter; go to SETTLE.
  - SETTLE:
    - Detect baud_clk_in rising edges using a registered copy of baud_clk_in.
    - Count rising edges; on the SETTLE_TICKS-th, go to DONE.
    - Edges seen before APPLY are not counted.
  - DONE, one cycle: cfg_done=1, go to IDLE.
  - AUTO_ARM: wait for rx_in==1, then go to AUTO_FALL.
  - AUTO_FALL: wait for rx_in==0 (start bit), then clear meas_cnt and go to AUTO_MEAS.
  - Timeout (AUTO_ARM and AUTO_FALL):
    - The timeout counter runs through both states.
    - On reaching AUTO_TIMEOUT, go to FAIL.
  - AUTO_MEAS:
    - meas_cnt increments every cycle while rx_in==0; the counter is 17 bits and saturating.
    - If meas_cnt reaches T_MAX=52083 (5/4 of the 2400 bit time) while rx_in is still low, go to FAIL.
    - On rx_in==1, classify meas_cnt:
      - >=31250 → 00
      - >=15625 → 01
      - >=7812 → 10
      - >=3906 → 11
      - <3906 → FAIL
    - After a successful classification: pend_rate<=code; go to WAIT_IDLE. The receiver finishes its garbage frame before the rate is applied.
  - FAIL, one cycle: auto_fail=1; baud_rate unchanged; go to IDLE.
- Thresholds:
  - Arithmetic midpoints of adjacent bit times, derived from CLK_FREQ. Values above are for 100 MHz.
  - Bit times are 41667, 20833, 10417 and 5208 cycles.
- A same-rate request still runs the full sequence and still pulses cfg_done.
- baud_rate changes only in APPLY. Requests arriving while busy are not accepted (req_ready=0). auto_req pulses while busy are ignored.

Decomposition:
- Package uart_pkg:
  - rate code localparams BAUD_2400..BAUD_19200;
  - CLK_FREQ default;
  - functions or localparams for the classification thresholds T_2400..T_19200 and T_MAX;
  - the state enumeration.
- Sub-module uart_autobaud_meas: AUTO_ARM/FALL/MEAS sub-sequence, timeout counter and classifier.
  - Inputs: start, rx_in.
  - Outputs: done pulse, fail pulse, rate[1:0].
- Top level: handshake, WAIT_IDLE/APPLY/SETTLE sequencing and output registers.

Test Plan:
1. Reset, then hold: baud_rate=10, req_ready=1, cfg_done=0. Pulse rst mid-SETTLE: next cycle baud_rate=10, state IDLE.
2. Manual request req_rate=00 with tx_busy=1 for 500 cycles: baud_rate stays 10, req_ready=0 throughout. tx_busy drops: baud_rate=00 one cycle later; cfg_done pulses exactly once, after 4 baud_clk_in rising edges.
3. Autobaud: rx_in high, then low for 5208 cycles, then high: baud_rate=11 and cfg_done pulses. Repeat with a 41667-cycle low: code 00.
4. Autobaud boundaries: low for 3905 cycles → auto_fail, baud_rate unchanged. Low for 3906 cycles → code 11. Low held ≥52083 cycles → auto_fail at cycle 52083.
5. auto_req with rx_in held high for AUTO_TIMEOUT cycles → auto_fail, busy=0 next cycle.
6. Same cycle req_valid(01)+auto_req → manual path wins, final baud_rate=01. A second req_valid while busy is not accepted (req_ready=0); a same-rate request still yields cfg_done.
